// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round-core scheduler.
package aes_pkg;

  localparam int unsigned AES_BLK_W      = 128;
  localparam int unsigned ARM_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves away from the winner on advance.
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // Pointer only matters when both channels compete.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

  // After a ch0 grant the pointer favours ch1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one AES-128 round core between two requesters with a watchdog and global hold.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned ARM_CYCLES = ARM_CYCLES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [AES_BLK_W-1:0] req_data0,
  input  logic [AES_BLK_W-1:0] req_data1,
  input  logic [TAG_W-1:0]     req_tag0,
  input  logic [TAG_W-1:0]     req_tag1,
  output logic                 core_start,
  output logic                 core_pause,
  output logic [AES_BLK_W-1:0] core_plaintext,
  input  logic                 core_ready,
  input  logic [AES_BLK_W-1:0] core_data_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [AES_BLK_W-1:0] res_data,
  output logic                 res_chan,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_err
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned ARM_W  = $clog2(ARM_CYCLES + 1);

  sched_state_t         state, state_nxt;
  logic [ARM_W-1:0]     arm_cnt, arm_cnt_nxt;
  logic [WDOG_W-1:0]    wdog, wdog_nxt;
  logic [AES_BLK_W-1:0] pt_nxt;
  logic [TAG_W-1:0]     job_tag, job_tag_nxt;
  logic                 job_chan, job_chan_nxt;
  logic                 res_valid_nxt;
  logic [AES_BLK_W-1:0] res_data_nxt;
  logic                 res_chan_nxt;
  logic [TAG_W-1:0]     res_tag_nxt;
  logic                 res_err_nxt;
  logic [1:0]           grant;
  logic                 advance;

  assign core_pause = hold;

  aes_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  // Next-state, job/result updates and the combinational handshake strobes.
  always_comb begin
    state_nxt     = state;
    arm_cnt_nxt   = arm_cnt;
    wdog_nxt      = wdog;
    pt_nxt        = core_plaintext;
    job_tag_nxt   = job_tag;
    job_chan_nxt  = job_chan;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    res_chan_nxt  = res_chan;
    res_tag_nxt   = res_tag;
    res_err_nxt   = res_err;
    req_ready     = 2'b00;
    core_start    = 1'b0;
    advance       = 1'b0;

    if (!hold) begin
      case (state)
        ST_IDLE: begin
          req_ready = grant;
          if ((req_valid & grant) != 2'b00) begin
            advance      = 1'b1;
            pt_nxt       = grant[1] ? req_data1 : req_data0;
            job_tag_nxt  = grant[1] ? req_tag1 : req_tag0;
            job_chan_nxt = grant[1];
            state_nxt    = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          core_start  = 1'b1;
          arm_cnt_nxt = '0;
          state_nxt   = ST_ARM;
        end
        ST_ARM: begin
          // core_ready may still be high from the previous job here.
          if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
            wdog_nxt  = '0;
            state_nxt = ST_WAIT;
          end else begin
            arm_cnt_nxt = arm_cnt + ARM_W'(1);
          end
        end
        ST_WAIT: begin
          if (core_ready) begin
            res_data_nxt  = core_data_out;
            res_err_nxt   = 1'b0;
            res_chan_nxt  = job_chan;
            res_tag_nxt   = job_tag;
            res_valid_nxt = 1'b1;
            state_nxt     = ST_DONE;
          end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
            res_data_nxt  = '0;
            res_err_nxt   = 1'b1;
            res_chan_nxt  = job_chan;
            res_tag_nxt   = job_tag;
            res_valid_nxt = 1'b1;
            state_nxt     = ST_DONE;
          end else if (wdog != '1) begin
            wdog_nxt = wdog + WDOG_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_nxt = 1'b0;
            state_nxt     = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, job and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      arm_cnt        <= '0;
      wdog           <= '0;
      core_plaintext <= '0;
      job_tag        <= '0;
      job_chan       <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_chan       <= 1'b0;
      res_tag        <= '0;
      res_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      arm_cnt        <= arm_cnt_nxt;
      wdog           <= wdog_nxt;
      core_plaintext <= pt_nxt;
      job_tag        <= job_tag_nxt;
      job_chan       <= job_chan_nxt;
      res_valid      <= res_valid_nxt;
      res_data       <= res_data_nxt;
      res_chan       <= res_chan_nxt;
      res_tag        <= res_tag_nxt;
      res_err        <= res_err_nxt;
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: stand-in round core, transaction-level model, directed tests.
module tb_aes_round_scheduler;

  localparam int TAG_W = 4;
  localparam int ARM   = 2;
  localparam int TMO   = 32;
  localparam logic [127:0] KNOWN_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KNOWN_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam int M_IDLE = 0;
  localparam int M_JOB  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [127:0]     req_data0 = '0;
  logic [127:0]     req_data1 = '0;
  logic [TAG_W-1:0] req_tag0 = '0;
  logic [TAG_W-1:0] req_tag1 = '0;
  logic             core_start;
  logic             core_pause;
  logic [127:0]     core_plaintext;
  logic             core_ready = 1'b0;
  logic [127:0]     core_data_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [127:0]     res_data;
  logic             res_chan;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  int checks = 0;
  int errors = 0;

  aes_round_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hold           (hold),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data0      (req_data0),
    .req_data1      (req_data1),
    .req_tag0       (req_tag0),
    .req_tag1       (req_tag1),
    .core_start     (core_start),
    .core_pause     (core_pause),
    .core_plaintext (core_plaintext),
    .core_ready     (core_ready),
    .core_data_out  (core_data_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_chan       (res_chan),
    .res_tag        (res_tag),
    .res_err        (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in round core: FIPS-197 vector for KNOWN_PT, a fixed scramble otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] p);
    if (p == KNOWN_PT) return KNOWN_CT;
    return {p[63:0], p[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
  endfunction

  int           core_lat = 3;
  bit           core_hang = 1'b0;
  logic         core_busy = 1'b0;
  int           core_cnt = 0;
  logic [127:0] core_pt = '0;

  // Core model: ready drops on start, rises core_lat edges later, frozen by pause.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready    <= 1'b0;
      core_busy     <= 1'b0;
      core_cnt      <= 0;
      core_data_out <= '0;
      core_pt       <= '0;
    end else if (!core_pause) begin
      if (core_start) begin
        core_busy  <= 1'b1;
        core_cnt   <= core_lat;
        core_ready <= 1'b0;
        core_pt    <= core_plaintext;
      end else if (core_busy && !core_hang) begin
        if (core_cnt <= 1) begin
          core_ready    <= 1'b1;
          core_busy     <= 1'b0;
          core_data_out <= core_fn(core_pt);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // Model: idle / job in flight / result pending; m_pos counts non-held cycles since grant.
  int               m_st = M_IDLE;
  int               m_pos = 0;
  logic             m_ptr = 1'b0;
  logic             m_chan = 1'b0;
  logic [127:0]     m_job_data = '0;
  logic [TAG_W-1:0] m_job_tag = '0;
  logic [127:0]     m_res_data = '0;
  logic             m_res_chan = 1'b0;
  logic [TAG_W-1:0] m_res_tag = '0;
  logic             m_res_err = 1'b0;

  function automatic int grant_fn(input logic ptr, input logic [1:0] v);
    if (v == 2'b11) return ptr ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] exp_ready();
    if (m_st != M_IDLE || hold || req_valid == 2'b00) return 2'b00;
    return (grant_fn(m_ptr, req_valid) == 1) ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= M_IDLE;
      m_ptr <= 1'b0;
      m_pos <= 0;
    end else if (!hold) begin
      case (m_st)
        M_IDLE: if (req_valid != 2'b00) begin
          m_chan     <= 1'(grant_fn(m_ptr, req_valid));
          m_ptr      <= (grant_fn(m_ptr, req_valid) == 0);
          m_job_data <= (grant_fn(m_ptr, req_valid) == 1) ? req_data1 : req_data0;
          m_job_tag  <= (grant_fn(m_ptr, req_valid) == 1) ? req_tag1 : req_tag0;
          m_pos      <= 0;
          m_st       <= M_JOB;
        end
        M_JOB: begin
          if (m_pos > ARM && core_ready) begin
            m_res_data <= core_fn(m_job_data);
            m_res_err  <= 1'b0;
            m_res_chan <= m_chan;
            m_res_tag  <= m_job_tag;
            m_st       <= M_DONE;
          end else if (m_pos - ARM - 1 == TMO - 1) begin
            m_res_data <= '0;
            m_res_err  <= 1'b1;
            m_res_chan <= m_chan;
            m_res_tag  <= m_job_tag;
            m_st       <= M_DONE;
          end else begin
            m_pos <= m_pos + 1;
          end
        end
        M_DONE: if (res_ready) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", 128'(req_ready), 128'(exp_ready()));
      chk("core_start", 128'(core_start), 128'(m_st == M_JOB && m_pos == 0 && !hold));
      chk("core_pause", 128'(core_pause), 128'(hold));
      chk("res_valid", 128'(res_valid), 128'(m_st == M_DONE));
      if (m_st != M_IDLE) chk("core_plaintext", core_plaintext, m_job_data);
      if (m_st == M_DONE) begin
        chk("res_data", res_data, m_res_data);
        chk("res_chan", 128'(res_chan), 128'(m_res_chan));
        chk("res_tag", 128'(res_tag), 128'(m_res_tag));
        chk("res_err", 128'(res_err), 128'(m_res_err));
      end
    end
  end

  int start_cnt = 0;
  int res_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && core_start) start_cnt <= start_cnt + 1;
    if (rst_n && !hold && res_valid && res_ready) res_cnt <= res_cnt + 1;
  end

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, 128'(req_ready), 128'h0);
    chk({pfx, "_core_start"}, 128'(core_start), 128'h0);
    chk({pfx, "_core_pause"}, 128'(core_pause), 128'h0);
    chk({pfx, "_core_plaintext"}, core_plaintext, 128'h0);
    chk({pfx, "_res_valid"}, 128'(res_valid), 128'h0);
    chk({pfx, "_res_data"}, res_data, 128'h0);
    chk({pfx, "_res_chan"}, 128'(res_chan), 128'h0);
    chk({pfx, "_res_tag"}, 128'(res_tag), 128'h0);
    chk({pfx, "_res_err"}, 128'(res_err), 128'h0);
  endtask

  // One job on one channel; lat = posedges from handshake edge to first res_valid cycle.
  task automatic run_job(input int ch, input logic [127:0] d, input logic [TAG_W-1:0] t,
                         input int rr_delay, output int lat, output logic [127:0] rd,
                         output logic re, output logic rc);
    int n;
    bit hs;
    bit got;
    @(posedge clk); #1;
    if (ch == 0) begin req_data0 = d; req_tag0 = t; end
    else begin req_data1 = d; req_tag1 = t; end
    req_valid[ch] = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = req_ready[ch];
      @(posedge clk); #1;
      n++;
    end
    req_valid[ch] = 1'b0;
    chk("handshake_seen", 128'(hs), 128'h1);
    lat = 1;
    got = 1'b0;
    while (hs && !got && lat < 100) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    chk("result_seen", 128'(got), 128'h1);
    rd = res_data;
    re = res_err;
    rc = res_chan;
    if (got) begin
      if (rr_delay > 0) begin repeat (rr_delay) @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
  endtask

  int order_q[$];

  // Both channels request concurrently; records grant order, res_ready held high.
  task automatic run_pair(input int n0, input int n1);
    int rem0;
    int rem1;
    int n;
    int hsc;
    rem0 = n0;
    rem1 = n1;
    order_q.delete();
    res_ready = 1'b1;
    @(posedge clk); #1;
    req_data0 = 128'ha0a0a0a0_11111111_22222222_33333333;
    req_data1 = 128'hb1b1b1b1_44444444_55555555_66666666;
    req_tag0  = 4'h1;
    req_tag1  = 4'h9;
    req_valid = {rem1 > 0, rem0 > 0};
    n = 0;
    while ((rem0 > 0 || rem1 > 0) && n < 1000) begin
      @(negedge clk);
      hsc = -1;
      if (req_valid[0] && req_ready[0]) hsc = 0;
      else if (req_valid[1] && req_ready[1]) hsc = 1;
      @(posedge clk); #1;
      n++;
      if (hsc == 0) begin
        order_q.push_back(0);
        rem0--;
        req_tag0  = req_tag0 + 4'h1;
        req_data0 = req_data0 + 128'h1357;
        if (rem0 == 0) req_valid[0] = 1'b0;
      end else if (hsc == 1) begin
        order_q.push_back(1);
        rem1--;
        req_tag1  = req_tag1 + 4'h1;
        req_data1 = req_data1 + 128'h2468;
        if (rem1 == 0) req_valid[1] = 1'b0;
      end
    end
    chk("pair_all_granted", 128'(rem0 == 0 && rem1 == 0), 128'h1);
    repeat (20) @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  int           lat;
  logic [127:0] rd;
  logic         re;
  logic         rc;
  int           s0;
  int           r0;
  int           exp2 [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    // Reset state
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single ch0 job with the known vector
    run_job(0, KNOWN_PT, 4'h3, 0, lat, rd, re, rc);
    chk("t1_latency", 128'(lat), 128'd6);
    chk("t1_data", rd, KNOWN_CT);
    chk("t1_chan", 128'(rc), 128'h0);
    chk("t1_err", 128'(re), 128'h0);

    // 3: result back-pressured for 20 cycles while ch1 requests
    s0 = start_cnt;
    fork
      run_job(0, 128'hdeadbeef_00000000_cafef00d_12345678, 4'h5, 20, lat, rd, re, rc);
      begin
        @(posedge clk); #1;
        repeat (10) @(posedge clk); #1;
        req_valid[1] = 1'b1;
        repeat (10) @(posedge clk); #1;
        req_valid[1] = 1'b0;
      end
    join
    chk("t3_latency", 128'(lat), 128'd6);
    chk("t3_single_start", 128'(start_cnt - s0), 128'd1);

    // 4: core never ready -> watchdog abort, then a clean job
    core_hang = 1'b1;
    run_job(0, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 4'h7, 0, lat, rd, re, rc);
    core_hang = 1'b0;
    chk("t4_latency", 128'(lat), 128'd36);
    chk("t4_err", 128'(re), 128'h1);
    chk("t4_data", rd, 128'h0);
    run_job(0, KNOWN_PT, 4'h8, 0, lat, rd, re, rc);
    chk("t4_next_latency", 128'(lat), 128'd6);
    chk("t4_next_data", rd, KNOWN_CT);
    chk("t4_next_err", 128'(re), 128'h0);

    // 5: hold pulses in LAUNCH, ARM and WAIT
    s0 = start_cnt;
    fork
      run_job(0, KNOWN_PT, 4'ha, 0, lat, rd, re, rc);
      begin
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
          @(posedge clk); #1;
          hold = (k == 1 || k == 3 || k == 7);
        end
        hold = 1'b0;
      end
    join
    chk("t5_latency", 128'(lat), 128'd9);
    chk("t5_data", rd, KNOWN_CT);
    chk("t5_single_start", 128'(start_cnt - s0), 128'd1);

    // 2: both channels, four jobs each, alternating grants
    r0 = res_cnt;
    run_pair(4, 4);
    chk("t2_grant_count", 128'(order_q.size()), 128'd8);
    if (order_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t2_grant_order", 128'(order_q[i]), 128'(exp2[i]));
    end
    chk("t2_results", 128'(res_cnt - r0), 128'd8);

    // 6: async reset in WAIT, then ch0 wins the first contested grant
    core_lat = 10;
    @(posedge clk); #1;
    req_data0 = KNOWN_PT;
    req_tag0  = 4'h2;
    req_valid = 2'b01;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    core_lat = 3;
    r0 = res_cnt;
    run_pair(1, 1);
    chk("t6_grant_count", 128'(order_q.size()), 128'd2);
    if (order_q.size() == 2) begin
      chk("t6_first_grant", 128'(order_q[0]), 128'd0);
      chk("t6_second_grant", 128'(order_q[1]), 128'd1);
    end
    chk("t6_results", 128'(res_cnt - r0), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

endmodule
